// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor sizing, panel FSM states, door encoding.
package elevator_pkg;

  localparam int N_FLOORS = 8;
  localparam int FLOOR_W  = $clog2(N_FLOORS);

  localparam logic DOOR_OPEN   = 1'b1;
  localparam logic DOOR_CLOSED = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } panel_state_t;

endpackage

// File: rtl/elevator_call_panel_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward
// from ptr+1 with wrap, found on a doubled request vector.
module rr_arbiter #(
  parameter int  N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [W:0]     w_start;
  logic [W:0]     w_off;
  logic [W+1:0]   w_sum;

  assign w_dbl = {req, req};

  always_comb begin
    w_start = (W+1)'(ptr) + (W+1)'(1);
    if (w_start >= (W+1)'(N))
      w_start = w_start - (W+1)'(N);
    w_rot     = N'(w_dbl >> w_start);
    gnt_valid = 1'b0;
    w_off     = '0;
    // descending scan so the lowest offset wins
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        gnt_valid = 1'b1;
        w_off     = (W+1)'(k);
      end
    end
    w_sum = (W+2)'(w_start) + (W+2)'(w_off);
    if (w_sum >= (W+2)'(N))
      w_sum = w_sum - (W+2)'(N);
    gnt_idx = w_sum[W-1:0];
  end

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel: latches button presses as lamps, issues one ip strobe per call.
// Optional ELEVATOR_CALL_PANEL_DEBOUNCE_EN adds per-button level filters.
module elevator_call_panel #(
  parameter int  N_FLOORS        = elevator_pkg::N_FLOORS,
  parameter int  GAP_CYCLES      = 2,
  parameter int  DEBOUNCE_CYCLES = 4,
  localparam int FLOOR_W         = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]  curr_floor,
  input  logic                door,
  output logic [FLOOR_W-1:0]  floor_no,
  output logic                ip,
  output logic [N_FLOORS-1:0] lamp,
  output logic                busy
);

  import elevator_pkg::*;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [N_FLOORS-1:0] w_btn;

`ifdef ELEVATOR_CALL_PANEL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0]       r_cnt [N_FLOORS];
  logic [N_FLOORS-1:0] r_filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= '0;
      for (int i = 0; i < N_FLOORS; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_FLOORS; i++) begin
        if (btn[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[i] <= btn[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_btn = r_filt;
`else
  assign w_btn = btn;
`endif

  panel_state_t        r_state;
  logic [N_FLOORS-1:0] r_pend;
  logic [N_FLOORS-1:0] r_sent;
  logic [N_FLOORS-1:0] r_btn_q;
  logic [FLOOR_W-1:0]  r_ptr;
  logic [FLOOR_W-1:0]  r_floor_no;
  logic [GW-1:0]       r_gap;
  logic                r_door_q;
  logic                r_ip;

  logic [N_FLOORS-1:0] w_lamp;
  logic [N_FLOORS-1:0] w_cf_hot;
  logic [N_FLOORS-1:0] w_sel_hot;
  logic [N_FLOORS-1:0] w_at;
  logic [N_FLOORS-1:0] w_clr;
  logic [N_FLOORS-1:0] w_press;
  logic [N_FLOORS-1:0] w_req;
  logic [N_FLOORS-1:0] w_pend_nx;
  logic [N_FLOORS-1:0] w_sent_nx;
  logic [FLOOR_W-1:0]  w_gnt_idx;
  logic                w_gnt_valid;
  logic                w_svc;

  assign w_lamp    = r_pend | r_sent;
  assign w_cf_hot  = N_FLOORS'(1) << curr_floor;
  assign w_sel_hot = N_FLOORS'(1) << r_floor_no;
  assign w_svc     = (door == DOOR_OPEN) && (r_door_q == DOOR_CLOSED);
  assign w_clr     = w_svc ? w_cf_hot : '0;
  // an open door at this floor already answers the call
  assign w_at      = (door == DOOR_OPEN) ? w_cf_hot : '0;
  assign w_press   = w_btn & ~r_btn_q & ~w_lamp & ~w_at;
  assign w_req     = r_pend & ~w_clr;

  rr_arbiter #(.N(N_FLOORS)) u_arb (
    .req       (w_req),
    .ptr       (r_ptr),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  always_comb begin
    w_pend_nx = (r_pend | w_press) & ~w_clr;
    w_sent_nx = r_sent & ~w_clr;
    if (r_state == ISSUE) begin
      w_pend_nx = w_pend_nx & ~w_sel_hot;
      w_sent_nx = w_sent_nx | (w_sel_hot & ~w_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_sent     <= '0;
      r_btn_q    <= '0;
      r_ptr      <= FLOOR_W'(N_FLOORS - 1);
      r_floor_no <= '0;
      r_gap      <= '0;
      r_door_q   <= DOOR_OPEN;
      r_ip       <= 1'b0;
    end else begin
      r_pend   <= w_pend_nx;
      r_sent   <= w_sent_nx;
      r_btn_q  <= w_btn;
      r_door_q <= door;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_floor_no <= w_gnt_idx;
            r_ip       <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_ip  <= 1'b0;
          r_ptr <= r_floor_no;
          if (GAP_CYCLES == 0) begin
            r_state <= IDLE;
          end else begin
            r_gap   <= GW'(GAP_CYCLES - 1);
            r_state <= GAP;
          end
        end
        GAP: begin
          if (r_gap == '0) r_state <= IDLE;
          else             r_gap   <= r_gap - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign floor_no = r_floor_no;
  assign ip       = r_ip;
  assign lamp     = w_lamp;
  assign busy     = (|r_pend) || (r_state != IDLE);

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed + random bench for elevator_call_panel against a call-set model.
module tb_elevator_call_panel;

  localparam int NF  = 8;
  localparam int GAP = 2;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic [2:0] curr_floor;
  logic       door;
  logic [2:0] floor_no;
  logic       ip;
  logic [7:0] lamp;
  logic       busy;

  elevator_call_panel #(
    .N_FLOORS        (NF),
    .GAP_CYCLES      (GAP),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .curr_floor (curr_floor),
    .door       (door),
    .floor_no   (floor_no),
    .ip         (ip),
    .lamp       (lamp),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int q_fl[$];
  int q_cy[$];

  bit           m_pend[NF];
  bit           m_sent[NF];
  bit           m_bprev[NF];
  bit           m_filt[NF];
  bit [DEB-1:0] m_hist[NF];
  bit           m_dprev;
  bit           m_issuing;
  int           m_ptr;
  int           m_fno;
  int           m_wait;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_pend[i]  = 0;
      m_sent[i]  = 0;
      m_bprev[i] = 0;
      m_filt[i]  = 0;
      m_hist[i]  = '0;
    end
    m_dprev   = 1;
    m_issuing = 0;
    m_ptr     = NF - 1;
    m_fno     = 0;
    m_wait    = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input logic d,
                            input int cf);
    bit eff[NF];
    bit pn[NF];
    bit sn[NF];
    bit svc;
    bit found;
    int idx;
    for (int i = 0; i < NF; i++) begin
`ifdef ELEVATOR_CALL_PANEL_DEBOUNCE_EN
      eff[i]    = m_filt[i];
      m_hist[i] = {m_hist[i][DEB-2:0], b[i]};
      if (&m_hist[i])       m_filt[i] = 1;
      else if (~|m_hist[i]) m_filt[i] = 0;
`else
      eff[i] = b[i];
`endif
    end
    svc = d && !m_dprev;
    for (int i = 0; i < NF; i++) begin
      pn[i] = m_pend[i];
      sn[i] = m_sent[i];
      if (eff[i] && !m_bprev[i] && !(m_pend[i] || m_sent[i])
          && !(d && cf == i))
        pn[i] = 1;
    end
    if (svc) begin
      pn[cf] = 0;
      sn[cf] = 0;
    end
    if (m_issuing) begin
      pn[m_fno] = 0;
      if (!(svc && cf == m_fno)) sn[m_fno] = 1;
      m_ptr     = m_fno;
      m_issuing = 0;
      m_wait    = GAP;
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      found = 0;
      for (int k = 1; k <= NF; k++) begin
        idx = (m_ptr + k) % NF;
        if (!found && m_pend[idx] && !(svc && cf == idx)) begin
          found     = 1;
          m_issuing = 1;
          m_fno     = idx;
        end
      end
    end
    for (int i = 0; i < NF; i++) begin
      m_pend[i]  = pn[i];
      m_sent[i]  = sn[i];
      m_bprev[i] = eff[i];
    end
    m_dprev = d;
  endtask

  task automatic cycle();
    logic [7:0] b;
    logic       d;
    logic       r;
    int         cf;
    logic [7:0] el;
    bit         eb;
    b  = btn;
    d  = door;
    r  = rst;
    cf = int'(curr_floor);
    @(posedge clk);
    if (r) model_reset();
    else   model_step(b, d, cf);
    #1;
    cyc++;
    eb = m_issuing || (m_wait > 0);
    for (int i = 0; i < NF; i++) begin
      el[i] = m_pend[i] | m_sent[i];
      eb    = eb | m_pend[i];
    end
    chk("ip", 32'(ip), 32'(m_issuing));
    chk("lamp", 32'(lamp), 32'(el));
    chk("busy", 32'(busy), 32'(eb));
    if (m_issuing) chk("floor_no", 32'(floor_no), 32'(m_fno));
    if (ip === 1'b1) begin
      q_fl.push_back(int'(floor_no));
      q_cy.push_back(cyc);
    end
  endtask

  task automatic service(input int f);
    curr_floor = 3'(f);
    door       = 1;
    cycle();
    door = 0;
    cycle();
  endtask

  initial begin
    int base;
    int n4;
    model_reset();
    rst        = 1;
    btn        = '0;
    door       = 0;
    curr_floor = '0;
    cycle();
    cycle();
    rst = 0;
    chk("rst_ip", 32'(ip), 0);
    chk("rst_lamp", 32'(lamp), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_floor_no", 32'(floor_no), 0);

`ifndef ELEVATOR_CALL_PANEL_DEBOUNCE_EN
    btn = 8'h20;
    cycle();
    chk("t1_pend", 32'(lamp), 32'h20);
    chk("t1_ip_early", 32'(ip), 0);
    btn = '0;
    cycle();
    chk("t1_ip", 32'(ip), 1);
    chk("t1_floor", 32'(floor_no), 5);
    cycle();
    chk("t1_ip_one", 32'(ip), 0);
    chk("t1_lamp_held", 32'(lamp), 32'h20);
    repeat (3) cycle();
    curr_floor = 3'd5;
    door       = 1;
    cycle();
    chk("t1_lamp_off", 32'(lamp), 0);
    door = 0;
    cycle();

    rst = 1;
    cycle();
    rst  = 0;
    base = q_fl.size();
    btn  = 8'h46;
    cycle();
    btn = '0;
    repeat (16) cycle();
    chk("t2_count", 32'(q_fl.size() - base), 3);
    if (q_fl.size() - base == 3) begin
      chk("t2_first", 32'(q_fl[base]), 1);
      chk("t2_second", 32'(q_fl[base+1]), 2);
      chk("t2_third", 32'(q_fl[base+2]), 6);
      chk("t2_space_a", 32'(q_cy[base+1] - q_cy[base]), 32'(GAP + 2));
      chk("t2_space_b", 32'(q_cy[base+2] - q_cy[base+1]), 32'(GAP + 2));
    end
    service(1);
    service(2);
    service(6);
    chk("t2_clear", 32'(lamp), 0);

    base       = q_fl.size();
    curr_floor = 3'd3;
    door       = 1;
    cycle();
    btn = 8'h08;
    cycle();
    btn = '0;
    repeat (4) cycle();
    chk("t3_lamp3", 32'(lamp[3]), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_no_ip", 32'(q_fl.size() - base), 0);
    door = 0;
    cycle();

    base = q_fl.size();
    btn  = 8'h10;
    cycle();
    btn = '0;
    cycle();
    btn = 8'h10;
    cycle();
    btn = '0;
    repeat (6) begin
      cycle();
      chk("t4_lamp4", 32'(lamp[4]), 1);
    end
    n4 = 0;
    for (int i = base; i < q_fl.size(); i++)
      if (q_fl[i] == 4) n4++;
    chk("t4_one_ip", 32'(n4), 1);
    service(4);

    btn = 8'h08;
    cycle();
    btn = '0;
    cycle();
    btn = 8'h81;
    cycle();
    btn = '0;
    chk("t5_lamp_gap", 32'(lamp), 32'h89);
    chk("t5_busy_gap", 32'(busy), 1);
    rst = 1;
    cycle();
    rst = 0;
    chk("t5_ip", 32'(ip), 0);
    chk("t5_lamp", 32'(lamp), 0);
    chk("t5_busy", 32'(busy), 0);
    base = q_fl.size();
    repeat (10) cycle();
    chk("t5_no_ip", 32'(q_fl.size() - base), 0);
`else
    base = q_fl.size();
    btn  = 8'h80;
    repeat (3) cycle();
    btn = '0;
    repeat (12) cycle();
    chk("t6_glitch", 32'(q_fl.size() - base), 0);
    chk("t6_glitch_lamp", 32'(lamp), 0);
    btn = 8'h80;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 6) btn = '0;
      chk("t6_ip", 32'(ip), 32'(k == DEB + 2));
      if (k == DEB + 2) chk("t6_floor", 32'(floor_no), 7);
    end
`endif

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      btn = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) door = ~door;
      if (!door) curr_floor = 3'($urandom_range(0, NF - 1));
      cycle();
    end
    rst = 0;
    btn = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
